// File: rtl/bin2bcd_iter_if.sv
// Request/result bundle for the iterative binary-to-BCD converter.
// Optional sign output is present only when BIN2BCD_SIGNED_EN is defined.
//
// Handshake: the master raises start with bin_in valid; the converter takes it
// on a rising clk edge only while not busy (IDLE or DONE). No ready signal is
// returned: busy high means start is being ignored. done is a one-cycle pulse
// and bcd_out/overflow(/sign) stay valid from that pulse until the next one.
interface bin2bcd_iter_if #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef BIN2BCD_SIGNED_EN
  logic                  sign;
`endif
  logic [1:0]            state_dbg;

`ifdef BIN2BCD_SIGNED_EN
  modport master (output start, bin_in,
                  input  busy, done, bcd_out, overflow, sign, state_dbg);
  modport slave  (input  start, bin_in,
                  output busy, done, bcd_out, overflow, sign, state_dbg);
`else
  modport master (output start, bin_in,
                  input  busy, done, bcd_out, overflow, state_dbg);
  modport slave  (input  start, bin_in,
                  output busy, done, bcd_out, overflow, state_dbg);
`endif
endinterface

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter, one operand bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin_in as two's complement and add a sign output.
module bin2bcd_iter #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  bin2bcd_iter_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [SW-1:0]    scr_q, scr_d;
  logic             ovf_stk_q, ovf_stk_d;
  logic [SW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;

  logic [SW-1:0]    scr_adj;
  logic [SW-1:0]    scr_shift;
  logic             ovf_shift;
  logic [WIDTH-1:0] load_val;

`ifdef BIN2BCD_SIGNED_EN
  logic             sgn_lat_q, sgn_lat_d;
  logic             sign_q, sign_d;

  // Negating the most negative value wraps to itself, which read as unsigned
  // is exactly its magnitude.
  always_comb begin
    load_val = bus.bin_in;
    if (bus.bin_in[WIDTH-1]) begin
      load_val = ~bus.bin_in + WIDTH'(1);
    end
  end
`else
  always_comb begin
    load_val = bus.bin_in;
  end
`endif

  // Per-digit +3 correction, then the chain shift with the operand MSB entering.
  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_shift = {scr_adj[SW-2:0], opnd_q[WIDTH-1]};
    ovf_shift = ovf_stk_q | scr_adj[SW-1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    scr_d     = scr_q;
    ovf_stk_d = ovf_stk_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    sgn_lat_d = sgn_lat_q;
    sign_d    = sign_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          cnt_d     = CW'(WIDTH);
          opnd_d    = load_val;
          scr_d     = '0;
          ovf_stk_d = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
          sgn_lat_d = bus.bin_in[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        scr_d     = scr_shift;
        ovf_stk_d = ovf_shift;
        opnd_d    = opnd_q << 1;
        cnt_d     = cnt_q - CW'(1);
        // Result registers are loaded from the final iteration's values on
        // the same edge that enters DONE, so they never show partial data.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = scr_shift;
          ovf_d   = ovf_shift;
`ifdef BIN2BCD_SIGNED_EN
          sign_d  = sgn_lat_q;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      scr_q     <= '0;
      ovf_stk_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      scr_q     <= scr_d;
      ovf_stk_q <= ovf_stk_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_lat_q <= 1'b0;
      sign_q    <= 1'b0;
    end else begin
      sgn_lat_q <= sgn_lat_d;
      sign_q    <= sign_d;
    end
  end

  assign bus.sign = sign_q;
`endif

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = (state_q == DONE);
  assign bus.bcd_out   = bcd_q;
  assign bus.overflow  = ovf_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Directed plus randomized bench for bin2bcd_iter (WIDTH=14, DIGITS=4).
// Expected results come from a decimal arithmetic model of the conversion.
module tb_bin2bcd_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  bin2bcd_iter_if #(.WIDTH(14), .DIGITS(4)) bus ();

  bin2bcd_iter #(.WIDTH(14), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic void model(input logic [13:0] v, output logic [15:0] bcd,
                                output logic ovf, output logic sgn);
    int m;
    sgn = 1'b0;
    m   = int'(v);
`ifdef BIN2BCD_SIGNED_EN
    if (v[13]) begin
      sgn = 1'b1;
      m   = 16384 - int'(v);
    end
`endif
    ovf = (m >= 10000);
    m   = m % 10000;
    bcd = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [13:0] v);
    logic [15:0] e_bcd;
    logic        e_ovf;
    logic        e_sgn;
    model(v, e_bcd, e_ovf, e_sgn);
    check({tag, ".bcd"}, 32'(bus.bcd_out), 32'(e_bcd));
    check({tag, ".ovf"}, 32'(bus.overflow), 32'(e_ovf));
`ifdef BIN2BCD_SIGNED_EN
    check({tag, ".sign"}, 32'(bus.sign), 32'(e_sgn));
`endif
  endtask

  // ---------------- driver ----------------
  // Drives start for one cycle; edges counts rising edges including the
  // accept edge until done is seen (40 means it never came).
  task automatic run_conv(input logic [13:0] v, output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = v;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        bus.start  = 1'b0;
        bus.bin_in = 14'($urandom);
      end
      if (bus.busy) busy_cyc++;
      if (bus.done) break;
    end
  endtask

  task automatic conv_and_check(input string tag, input logic [13:0] v);
    int edges;
    int busy_cyc;
    run_conv(v, edges, busy_cyc);
    check({tag, ".latency"}, 32'(edges), 32'd15);
    check_result(tag, v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          edges;
    int          busy_cyc;
    int          n_done;
    logic [15:0] held;
    logic [13:0] rv;

    bus.start  = 1'b0;
    bus.bin_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.bcd", 32'(bus.bcd_out), 32'd0);
    check("rst.ovf", 32'(bus.overflow), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // 1110: latency, busy length, result, single pulse
    run_conv(14'd1110, edges, busy_cyc);
    check("c1110.latency", 32'(edges), 32'd15);
    check("c1110.busy_cycles", 32'(busy_cyc), 32'd14);
    check("c1110.bcd_lit", 32'(bus.bcd_out), 32'h1110);
    check("c1110.ovf_lit", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    check("c1110.done_one_cycle", 32'(bus.done), 32'd0);
    check("c1110.idle_not_busy", 32'(bus.busy), 32'd0);

    // Boundary values
    conv_and_check("c0", 14'd0);
    check("c0.bcd_lit", 32'(bus.bcd_out), 32'h0000);
`ifndef BIN2BCD_SIGNED_EN
    conv_and_check("c9999", 14'd9999);
    check("c9999.bcd_lit", 32'(bus.bcd_out), 32'h9999);
    check("c9999.ovf_lit", 32'(bus.overflow), 32'd0);
    conv_and_check("c16383", 14'd16383);
    check("c16383.bcd_lit", 32'(bus.bcd_out), 32'h6383);
    check("c16383.ovf_lit", 32'(bus.overflow), 32'd1);
`else
    conv_and_check("c8191", 14'd8191);
    conv_and_check("cneg1", 14'h3fff);
`endif

    // Result holds stable while idle
    held = bus.bcd_out;
    repeat (6) @(negedge clk);
    check("hold.bcd", 32'(bus.bcd_out), 32'(held));

    // start re-asserted with 42 during SHIFT is ignored
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'd1110;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'd42;
    @(negedge clk);
    bus.start  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("ignore.done_pulses", 32'(n_done), 32'd1);
    check("ignore.bcd", 32'(bus.bcd_out), 32'h1110);

    // Reset mid-conversion: immediate clear, no done, start ignored
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'd1110;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.bcd", 32'(bus.bcd_out), 32'd0);
    check("abort.ovf", 32'(bus.overflow), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    bus.start = 1'b1;
    n_done = 0;
    busy_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
      if (bus.busy) busy_cyc++;
    end
    check("abort.no_done", 32'(n_done), 32'd0);
    check("abort.start_ignored", 32'(busy_cyc), 32'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    conv_and_check("c250", 14'd250);
    check("c250.bcd_lit", 32'(bus.bcd_out), 32'h0250);

    // Back-to-back: start held high gives a result every 15 cycles
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'd1110;
    edges = 0;
    while (edges < 40 && !bus.done) begin
      @(negedge clk);
      edges++;
    end
    bus.bin_in = 14'd777;
    edges = 0;
    @(negedge clk);
    while (edges < 40 && !bus.done) begin
      @(negedge clk);
      edges++;
    end
    check("b2b.period", 32'(edges + 1), 32'd15);
    check_result("b2b.second", 14'd777);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b.idle", 32'(bus.busy), 32'd0);

`ifdef BIN2BCD_SIGNED_EN
    conv_and_check("cm1234", 14'(16384 - 1234));
    check("cm1234.bcd_lit", 32'(bus.bcd_out), 32'h1234);
    check("cm1234.sign_lit", 32'(bus.sign), 32'd1);
    conv_and_check("cm8192", 14'h2000);
    check("cm8192.bcd_lit", 32'(bus.bcd_out), 32'h8192);
    check("cm8192.sign_lit", 32'(bus.sign), 32'd1);
`endif

    // Randomized operands
    for (int i = 0; i < 16; i++) begin
      rv = 14'($urandom_range(0, 16383));
      conv_and_check($sformatf("rand%0d", i), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
